tx_5g_ctrl: RTL and testbench

- TX-side framer for 10G/5G/2.5G speed modes; the transmit counterpart of the RX 5G/2.5G path.
- Pops a byte count and frame payload words from the TX byte-count/data FIFOs.
- Emits XGMII-style 64-bit data/8-bit ctrl words: start+preamble word, payload, terminate, idle gap.
- In 5G/2.5G modes, words are paced by a strobe; 1G mode is handled elsewhere and this block stays idle.

---
 rtl/tx_5g_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_tx_5g_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_5g_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tx_5g_ctrl : XGMII-style TX framer for 10G/5G/2.5G, strobe paced  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tx_5g_ctrl #(
  parameter int IPG_WORDS = 2
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        mode_10G,
  input  logic        mode_5G,
  input  logic        mode_2p5G,
  input  logic        mode_1G,
  input  logic        bcnt_empty,
  input  logic [15:0] bcnt_in,
  output logic        bcnt_re,
  input  logic [63:0] data_in,
  output logic        data_re,
  output logic [63:0] data_out,
  output logic [7:0]  ctrl_out,
  output logic        tx_we,
  output logic        busy
);

  localparam logic [63:0] C_IDLE_W = 64'h0707_0707_0707_0707;
  localparam logic [63:0] C_PRE_W  = 64'hD555_5555_5555_55FB;
  localparam logic [63:0] C_TERM_W = 64'h0707_0707_0707_07FD;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LDCNT = 3'd1,
    S_PRE   = 3'd2,
    S_DATA  = 3'd3,
    S_TERM  = 3'd4,
    S_IPG   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  mode_buf_q;   // {1G, 2p5G, 5G, 10G}
  logic [2:0]  mode_frm_q;   // speed held for the frame in flight
  logic [1:0]  cnt_q;
  logic [13:0] wleft_q, wleft_d;
  logic [3:0]  rem_q, rem_d;
  logic [3:0]  ipg_q, ipg_d;
  logic        rd_pend_q;
  logic [63:0] buf_q;
  logic [63:0] dout_q, dout_d;
  logic [7:0]  cout_q, cout_d;
  logic        we_q;

  logic [2:0]  w_mode;
  logic        w_strobe;
  logic [63:0] w_word;
  logic [63:0] w_last_d;
  logic [7:0]  w_last_c;

  // FIFO data is only guaranteed the cycle after the read, so keep a copy for slow modes.
  assign w_word = rd_pend_q ? data_in : buf_q;

  always_comb begin
    w_mode   = (state_q == S_IDLE) ? mode_buf_q[2:0] : mode_frm_q;
    w_strobe = w_mode[0] | (w_mode[1] & ~cnt_q[0]) | (w_mode[2] & (cnt_q == 2'd0));
    if (state_q == S_IDLE && mode_buf_q[3]) begin
      w_strobe = 1'b0;
    end
  end

  always_comb begin
    w_last_d = w_word;
    w_last_c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) == rem_q) begin
        w_last_d[8*i +: 8] = 8'hFD;
        w_last_c[i]        = 1'b1;
      end else if (4'(i) > rem_q) begin
        w_last_d[8*i +: 8] = 8'h07;
        w_last_c[i]        = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wleft_d = wleft_q;
    rem_d   = rem_q;
    ipg_d   = ipg_q;
    dout_d  = dout_q;
    cout_d  = cout_q;
    bcnt_re = 1'b0;
    data_re = 1'b0;
    if (w_strobe) begin
      dout_d = C_IDLE_W;
      cout_d = 8'hFF;
    end
    case (state_q)
      S_IDLE: begin
        if (!bcnt_empty && !mode_buf_q[3] && (|mode_buf_q[2:0])) begin
          bcnt_re = 1'b1;
          state_d = S_LDCNT;
        end
      end
      S_LDCNT: begin
        if (bcnt_in == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          wleft_d = {1'b0, bcnt_in[15:3]} + {13'd0, |bcnt_in[2:0]};
          rem_d   = (bcnt_in[2:0] == 3'd0) ? 4'd8 : {1'b0, bcnt_in[2:0]};
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (w_strobe) begin
          dout_d  = C_PRE_W;
          cout_d  = 8'h01;
          data_re = 1'b1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_strobe) begin
          if (wleft_q == 14'd1) begin
            ipg_d = 4'd0;
            if (rem_q == 4'd8) begin
              dout_d  = w_word;
              cout_d  = 8'h00;
              state_d = S_TERM;
            end else begin
              dout_d  = w_last_d;
              cout_d  = w_last_c;
              state_d = S_IPG;
            end
          end else begin
            dout_d  = w_word;
            cout_d  = 8'h00;
            data_re = 1'b1;
            wleft_d = wleft_q - 14'd1;
          end
        end
      end
      S_TERM: begin
        if (w_strobe) begin
          dout_d  = C_TERM_W;
          cout_d  = 8'hFF;
          ipg_d   = 4'd0;
          state_d = S_IPG;
        end
      end
      S_IPG: begin
        if (w_strobe) begin
          if (ipg_q == 4'(IPG_WORDS - 1)) begin
            state_d = S_IDLE;
          end else begin
            ipg_d = ipg_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reset_) begin
      bcnt_re = 1'b0;
      data_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_) begin
      state_q    <= S_IDLE;
      mode_buf_q <= 4'd0;
      mode_frm_q <= 3'd0;
      cnt_q      <= 2'd0;
      wleft_q    <= 14'd0;
      rem_q      <= 4'd0;
      ipg_q      <= 4'd0;
      rd_pend_q  <= 1'b0;
      buf_q      <= 64'd0;
      dout_q     <= C_IDLE_W;
      cout_q     <= 8'hFF;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_buf_q <= {mode_1G, mode_2p5G, mode_5G, mode_10G};
      if (state_q == S_IDLE) begin
        mode_frm_q <= mode_buf_q[2:0];
      end
      cnt_q      <= cnt_q + 2'd1;
      wleft_q    <= wleft_d;
      rem_q      <= rem_d;
      ipg_q      <= ipg_d;
      rd_pend_q  <= data_re;
      if (rd_pend_q) begin
        buf_q <= data_in;
      end
      dout_q     <= dout_d;
      cout_q     <= cout_d;
      we_q       <= w_strobe;
    end
  end

  assign data_out = dout_q;
  assign ctrl_out = cout_q;
  assign tx_we    = we_q;
  assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tx_5g_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_tx_5g_ctrl : bench for tx_5g_ctrl with FIFO model and scoreboard|
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_tx_5g_ctrl;

  localparam int          IPG_WORDS = 2;
  localparam logic [63:0] C_IDLE    = 64'h0707_0707_0707_0707;
  localparam logic [63:0] C_PRE     = 64'hD555_5555_5555_55FB;
  localparam logic [63:0] C_TERM    = 64'h0707_0707_0707_07FD;

  logic        clk = 1'b0;
  logic        reset_ = 1'b1;
  logic        mode_10G = 1'b1, mode_5G = 1'b0, mode_2p5G = 1'b0, mode_1G = 1'b0;
  logic        bcnt_empty = 1'b1;
  logic [15:0] bcnt_in = 16'd0;
  logic [63:0] data_in = 64'd0;
  logic        bcnt_re, data_re, tx_we, busy;
  logic [63:0] data_out;
  logic [7:0]  ctrl_out;

  tx_5g_ctrl #(.IPG_WORDS(IPG_WORDS)) dut (
    .clk(clk), .reset_(reset_),
    .mode_10G(mode_10G), .mode_5G(mode_5G), .mode_2p5G(mode_2p5G), .mode_1G(mode_1G),
    .bcnt_empty(bcnt_empty), .bcnt_in(bcnt_in), .bcnt_re(bcnt_re),
    .data_in(data_in), .data_re(data_re),
    .data_out(data_out), .ctrl_out(ctrl_out), .tx_we(tx_we), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic [7:0] c; } exp_t;
  typedef struct { int mode; int bcnt; int nonidle; logic [7:0] lctrl; int dre; int gap; } vec_t;

  // upstream FIFO contents: written only by the stimulus, consumed only by the FIFO model
  logic [15:0] bmem [0:255];
  logic [63:0] dmem [0:4095];
  int bwr = 0, dwr = 0, brd = 0, drd = 0, d_skip_to = 0;

  exp_t exp_q[$];
  int   n_total = 0, n_bad = 0;
  int   n_dre = 0, n_bre = 0, n_we = 0, n_nonidle = 0, cyc = 0;
  int   gmin = 999, gmax = 0, glast = -1, g;
  logic [7:0]  last_ni_ctrl = 8'h00;
  logic [71:0] prev = {C_IDLE, 8'hFF};
  logic        sb_en = 1'b1, is_idle;
  exp_t        em;

  always @(posedge clk) begin
    if (data_re) begin
      data_in <= dmem[drd % 4096];
      drd     <= drd + 1;
    end else if (drd < d_skip_to) begin
      drd <= d_skip_to;
    end
    if (bcnt_re) begin
      bcnt_in <= bmem[brd % 256];
      brd     <= brd + 1;
    end
    bcnt_empty <= ((bcnt_re ? brd + 1 : brd) == bwr);
  end

  // monitor + scoreboard, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (data_re) n_dre++;
      if (bcnt_re) n_bre++;
      if (!reset_) begin
        if (tx_we) begin
          n_we++;
          if (glast >= 0) begin
            g = cyc - glast;
            if (g < gmin) gmin = g;
            if (g > gmax) gmax = g;
          end
          glast   = cyc;
          is_idle = (data_out == C_IDLE) && (ctrl_out == 8'hFF);
          if (!is_idle) begin
            n_nonidle++;
            last_ni_ctrl = ctrl_out;
          end
          if (sb_en) begin
            if (is_idle && (exp_q.size() == 0 || (exp_q[0].d == C_PRE && exp_q[0].c == 8'h01))) begin
              n_we = n_we;
            end else if (exp_q.size() == 0) begin
              n_total++; n_bad++;
              $display("FAIL sb_extra: got d=%h c=%h, expected no word", data_out, ctrl_out);
            end else begin
              em = exp_q.pop_front();
              n_total++;
              if (data_out !== em.d || ctrl_out !== em.c) begin
                n_bad++;
                $display("FAIL sb_word: got d=%h c=%h expected d=%h c=%h", data_out, ctrl_out, em.d, em.c);
              end
            end
          end
        end else begin
          n_total++;
          if ({data_out, ctrl_out} !== prev) begin
            n_bad++;
            $display("FAIL hold: got %h expected held %h", {data_out, ctrl_out}, prev);
          end
        end
      end
      prev = {data_out, ctrl_out};
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_mode(input int m);
    mode_10G  = (m == 0);
    mode_5G   = (m == 1);
    mode_2p5G = (m == 2);
    mode_1G   = (m == 3);
  endtask

  // frame model: byte count -> FIFO contents and expected XGMII word stream
  task automatic push_frame(input int b, inout int exp_dre);
    int nw, rem;
    exp_t e;
    bmem[bwr % 256] = 16'(b);
    bwr++;
    if (b == 0) return;
    nw  = (b + 7) / 8;
    rem = (b % 8 == 0) ? 8 : b % 8;
    exp_q.push_back('{C_PRE, 8'h01});
    for (int k = 0; k < nw; k++) begin
      e.d = {$urandom, $urandom};
      e.c = 8'h00;
      dmem[dwr % 4096] = e.d;
      dwr++;
      if (k == nw - 1 && rem < 8) begin
        for (int l = rem; l < 8; l++) begin
          e.d[8*l +: 8] = (l == rem) ? 8'hFD : 8'h07;
          e.c[l]        = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
    exp_dre += nw;
    if (rem == 8) exp_q.push_back('{C_TERM, 8'hFF});
    for (int k = 0; k < IPG_WORDS; k++) exp_q.push_back('{C_IDLE, 8'hFF});
  endtask

  task automatic wait_done(input int budget);
    int k;
    repeat (3) @(posedge clk);
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && bcnt_empty) break;
    end
    n_total++;
    if (k >= budget) begin
      n_bad++;
      $display("FAIL wait_done: got timeout after %0d cycles, expected frame completion", budget);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  vec_t vt[8];
  int   ni0, dre0, bre0, we0, edre, k;
  bit   rand_done;

  initial begin
    vt[0] = '{0, 64, 10, 8'hFF, 8, 1};
    vt[1] = '{0, 61,  9, 8'hE0, 8, 1};
    vt[2] = '{1, 16,  4, 8'hFF, 2, 2};
    vt[3] = '{2, 16,  4, 8'hFF, 2, 4};
    vt[4] = '{0,  9,  3, 8'hFE, 2, 1};
    vt[5] = '{1,  1,  2, 8'hFE, 1, 2};
    vt[6] = '{0,  8,  3, 8'hFF, 1, 1};
    vt[7] = '{2, 15,  3, 8'h80, 2, 4};
    edre  = 0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_data", data_out, C_IDLE);
    chk("rst_ctrl", ctrl_out, 8'hFF);
    chk("rst_we", tx_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bre", bcnt_re, 0);
    chk("rst_dre", data_re, 0);
    @(posedge clk); #1;
    reset_ = 1'b0;

    for (int i = 0; i < 8; i++) begin
      set_mode(vt[i].mode);
      repeat (6) @(posedge clk);
      #1;
      gmin = 999; gmax = 0; glast = -1;
      ni0 = n_nonidle; dre0 = n_dre; bre0 = n_bre;
      push_frame(vt[i].bcnt, edre);
      wait_done(400);
      chk($sformatf("v%0d_words", i), n_nonidle - ni0, vt[i].nonidle);
      chk($sformatf("v%0d_lctrl", i), last_ni_ctrl, vt[i].lctrl);
      chk($sformatf("v%0d_dre", i), n_dre - dre0, vt[i].dre);
      chk($sformatf("v%0d_bre", i), n_bre - bre0, 1);
      chk($sformatf("v%0d_gapmin", i), gmin, vt[i].gap);
      chk($sformatf("v%0d_gapmax", i), gmax, vt[i].gap);
    end

    // zero-length frame queued ahead of a 9-byte frame
    set_mode(0);
    repeat (4) @(posedge clk); #1;
    ni0 = n_nonidle; dre0 = n_dre; bre0 = n_bre;
    push_frame(0, edre);
    push_frame(9, edre);
    wait_done(400);
    chk("zero_bre", n_bre - bre0, 2);
    chk("zero_dre", n_dre - dre0, 2);
    chk("zero_words", n_nonidle - ni0, 3);

    // 1G: block stays quiet with a frame pending
    set_mode(3);
    repeat (6) @(posedge clk); #1;
    we0 = n_we; bre0 = n_bre;
    push_frame(24, edre);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("g1_we", n_we - we0, 0);
    chk("g1_bre", n_bre - bre0, 0);
    chk("g1_busy", busy, 0);
    chk("g1_data", data_out, C_IDLE);
    chk("g1_ctrl", ctrl_out, 8'hFF);
    @(posedge clk); #1;
    set_mode(0);
    wait_done(400);
    chk("g1_after_bre", n_bre - bre0, 1);

    // reset in the middle of a 64-byte frame
    dre0 = n_dre;
    push_frame(64, edre);
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (n_dre - dre0 >= 3) break;
    end
    chk("mid_reach_data", (k < 200), 1);
    chk("mid_busy", busy, 1);
    @(posedge clk); #1;
    reset_ = 1'b1;
    sb_en  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_data", data_out, C_IDLE);
    chk("mid_rst_ctrl", ctrl_out, 8'hFF);
    chk("mid_rst_we", tx_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dre", data_re, 0);
    @(posedge clk); #1;
    exp_q.delete();
    d_skip_to = dwr;
    bre0 = n_bre;
    push_frame(64, edre);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_bre", bcnt_re, 0);
    chk("mid_rst_nbre", n_bre - bre0, 0);
    @(posedge clk); #1;
    reset_ = 1'b0;
    sb_en  = 1'b1;
    ni0 = n_nonidle; dre0 = n_dre;
    wait_done(400);
    chk("post_rst_words", n_nonidle - ni0, 10);
    chk("post_rst_dre", n_dre - dre0, 8);
    chk("post_rst_bre", n_bre - bre0, 1);

    // random frames with speed changes at random times
    dre0 = n_dre; bre0 = n_bre; edre = 0; rand_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          if ($urandom_range(0, 7) == 0) push_frame(0, edre);
          else push_frame(int'($urandom_range(1, 80)), edre);
        end
        wait_done(20000);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          repeat ($urandom_range(5, 60)) @(posedge clk);
          #1;
          if (!rand_done) set_mode(int'($urandom_range(0, 2)));
        end
      end
    join
    chk("rnd_dre", n_dre - dre0, edre);
    chk("rnd_bre", n_bre - bre0, 40);
    chk("rnd_exp_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #600000;
    n_bad++;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
